// File: rtl/mem_stage.sv
// Memory-access stage: fixed-latency word-addressed data SRAM with a ready handshake
// that freezes the upstream pipeline while a load or store is in flight.
module mem_stage #(
  parameter int WAIT_CYCLES = 3,
  parameter int DEPTH       = 64,
  parameter int BASE_ADDR   = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEM_R_EN,
  input  logic        MEM_W_EN,
  input  logic [31:0] ALU_result,
  input  logic [31:0] Val_Rm,
  output logic [31:0] MEM_result,
  output logic        ready
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [31:0] res_q;
  logic [31:0] mem [DEPTH];

  logic          req;
  logic [31:0]   offset;
  logic          in_range;
  logic [AW-1:0] idx;
  logic          last_wait;

  assign req       = MEM_R_EN | MEM_W_EN;
  assign offset    = ALU_result - 32'(BASE_ADDR);
  // Full-width compare keeps the byte-offset bits from mattering while still range-checking the top.
  assign in_range  = (ALU_result >= 32'(BASE_ADDR)) && (offset < 32'(DEPTH) * 32'd4);
  assign idx       = offset[AW+1:2];
  assign last_wait = (state_q == S_WAIT) && (cnt_q == 4'(WAIT_CYCLES - 1));

  assign ready      = (state_q == S_DONE) || ((state_q == S_IDLE) && !req);
  assign MEM_result = res_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (req) begin
            cnt_q   <= '0;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q + 4'd1;
          if (last_wait) begin
            if (MEM_R_EN && !MEM_W_EN)
              res_q <= in_range ? mem[idx] : 32'd0;
            state_q <= S_DONE;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Reset forces state to IDLE asynchronously, so an aborted store can never reach last_wait.
  always_ff @(posedge clk) begin
    if (last_wait && MEM_W_EN && in_range)
      mem[idx] <= Val_Rm;
  end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: per-cycle expectations from a word-array model, directed
// scenarios with literal checks, then a randomized load/store mix and full readback.
module tb_mem_stage;
  localparam int W    = 3;
  localparam int D    = 64;
  localparam int BASE = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd = 1'b0, wr = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [31:0] res;
  logic        rdy;

  mem_stage #(.WAIT_CYCLES(W), .DEPTH(D), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .MEM_R_EN(rd), .MEM_W_EN(wr),
    .ALU_result(addr), .Val_Rm(wdata), .MEM_result(res), .ready(rdy)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  logic [31:0] mdl [D];
  logic [31:0] mdl_res = '0;
  logic        exp_vld = 1'b0;
  logic        exp_rdy = 1'b1;
  logic [31:0] exp_res = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit in_rng(input logic [31:0] a);
    return (a >= BASE) && (((a - BASE) / 4) < D);
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a - BASE) / 4);
  endfunction

  always @(negedge clk) begin
    if (exp_vld && !rst) begin
      check("ready", 32'(rdy), 32'(exp_rdy));
      check("MEM_result", res, exp_res);
    end
  end

  // Called just after a rising edge; returns the same way after the access finishes.
  task automatic access(input bit r, input bit w, input logic [31:0] a,
                        input logic [31:0] d, output int lows);
    rd = r; wr = w; addr = a; wdata = d; lows = 0;
    for (int c = 0; c < W + 2; c++) begin
      exp_rdy = (c == W + 1);
      if (c == W + 1) begin
        if (w) begin
          if (in_rng(a)) mdl[widx(a)] = d;
        end else if (r) begin
          mdl_res = in_rng(a) ? mdl[widx(a)] : 32'd0;
        end
      end
      exp_res = mdl_res;
      exp_vld = 1'b1;
      @(negedge clk);
      if (!rdy) lows++;
      @(posedge clk); #1;
    end
    rd = 1'b0; wr = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) begin
      rd = 1'b0; wr = 1'b0; addr = $urandom; wdata = $urandom;
      exp_rdy = 1'b1; exp_res = mdl_res; exp_vld = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int lows;
    logic [31:0] a;
    // Asynchronous reset at time 0, checked before any clock edge.
    #1;
    check("reset_ready", 32'(rdy), 32'd1);
    check("reset_result", res, 32'd0);
    #13 rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < D; i++) access(1'b0, 1'b1, 32'(BASE + 4 * i), $urandom, lows);

    access(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, lows);
    check("store_low_cycles", 32'(lows), 32'd4);
    access(1'b1, 1'b0, 32'd1024, 32'd0, lows);
    check("load_low_cycles", 32'(lows), 32'd4);
    check("load_1024", res, 32'hDEADBEEF);
    access(1'b1, 1'b0, 32'd1026, 32'd0, lows);
    check("load_1026", res, 32'hDEADBEEF);
    access(1'b1, 1'b0, 32'd1027, 32'd0, lows);
    check("load_1027", res, 32'hDEADBEEF);
    idle(2);
    check("hold_ready", 32'(rdy), 32'd1);
    check("hold_result", res, 32'hDEADBEEF);

    access(1'b0, 1'b1, 32'd1276, 32'hA5A5A5A5, lows);
    access(1'b1, 1'b0, 32'd1276, 32'd0, lows);
    check("load_1276", res, 32'hA5A5A5A5);
    access(1'b0, 1'b1, 32'd1280, 32'h77777777, lows);
    access(1'b1, 1'b0, 32'd1280, 32'd0, lows);
    check("load_1280", res, 32'd0);
    access(1'b1, 1'b0, 32'd1024, 32'd0, lows);
    access(1'b1, 1'b0, 32'd1020, 32'd0, lows);
    check("load_1020", res, 32'd0);

    access(1'b1, 1'b1, 32'd1032, 32'h0000CAFE, lows);
    check("both_en_result", res, 32'd0);
    access(1'b1, 1'b0, 32'd1032, 32'd0, lows);
    check("load_1032", res, 32'h0000CAFE);

    // Reset during the second WAIT cycle of a store must leave memory untouched.
    access(1'b0, 1'b1, 32'd1028, 32'h11111111, lows);
    rd = 1'b0; wr = 1'b1; addr = 32'd1028; wdata = 32'h12345678;
    exp_rdy = 1'b0; exp_res = mdl_res; exp_vld = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #2;
    exp_vld = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_mid_ready_req", 32'(rdy), 32'd0);
    check("rst_mid_result", res, 32'd0);
    wr = 1'b0;
    #1;
    check("rst_mid_ready_idle", 32'(rdy), 32'd1);
    mdl_res = '0;
    @(posedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #1;
    access(1'b1, 1'b0, 32'd1028, 32'd0, lows);
    check("load_1028_after_abort", res, 32'h11111111);

    for (int k = 0; k < 250; k++) begin
      case ($urandom_range(0, 9))
        0:       a = $urandom;
        1:       a = 32'(BASE - 4 * $urandom_range(1, 4)) + 32'($urandom_range(0, 3));
        2:       a = 32'(BASE + 4 * D + 4 * $urandom_range(0, 4)) + 32'($urandom_range(0, 3));
        default: a = 32'(BASE + 4 * $urandom_range(0, D - 1)) + 32'($urandom_range(0, 3));
      endcase
      case ($urandom_range(0, 3))
        0:       access(1'b0, 1'b1, a, $urandom, lows);
        1:       access(1'b1, 1'b1, a, $urandom, lows);
        default: access(1'b1, 1'b0, a, 32'd0, lows);
      endcase
      check("rand_low_cycles", 32'(lows), 32'(W + 1));
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end

    for (int i = 0; i < D; i++) access(1'b1, 1'b0, 32'(BASE + 4 * i), 32'd0, lows);

    exp_vld = 1'b0;
    @(posedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the ARM pipeline, between the EXE stage register and the MEM stage register. Performs data-memory loads and stores against an internal word-addressed data memory that models a fixed-latency SRAM. Exposes a `ready` handshake that the hazard/freeze logic uses to stall all upstream stage registers while an access is in progress. On the cycle `ready` is high, `MEM_result` is valid for the MEM stage register to capture.

## Interface
- `WAIT_CYCLES`, default 3: SRAM wait states per access; legal range 1–15.
- `DEPTH`, default 64: data memory size in 32-bit words; power of two.
- `BASE_ADDR`, default 1024: byte address mapped to word 0.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `MEM_R_EN`  in  1  load request.
- `MEM_W_EN`  in  1  store request.
- `ALU_result`  in  32  byte address from EXE.
- `Val_Rm`  in  32  store data.
- `MEM_result`  out  32  load data, registered.
- `ready`  out  1  high: stage may advance this cycle; low: freeze upstream.

## Operation
- `req = MEM_R_EN | MEM_W_EN`. When both are high, treat as a store: `MEM_result` is unchanged.
- Address map:
  - `index = (ALU_result - BASE_ADDR) >> 2`; bits [1:0] are ignored.
  - In range iff `ALU_result >= BASE_ADDR` and `index < DEPTH`.
  - Out-of-range store: dropped, memory unchanged.
  - Out-of-range load: returns 0.
- FSM states: IDLE, WAIT, DONE. A 4-bit counter `cnt` is used in WAIT.
  - IDLE with `!req`: `ready`=1, stay in IDLE.
  - IDLE with `req`: `ready`=0, `cnt`←0, go to WAIT.
  - WAIT: `ready`=0, `cnt`←`cnt`+1.
  - WAIT, at the edge where `cnt == WAIT_CYCLES-1`:
    - store: commit `Val_Rm` to `mem[index]`.
    - load: `MEM_result`←`mem[index]`.
    - go to DONE.
  - DONE: `ready`=1, go to IDLE unconditionally.
- `ready` is combinational from state and `req`. It is high in DONE or in IDLE with `!req`.
- Inputs must stay stable from the IDLE-with-req cycle through DONE. The upstream freeze guarantees this; the block does not re-sample them.
- `MEM_result` holds its last load value across non-load cycles and stores.
- The memory array has no reset. Contents are undefined until written.
- Reset (asynchronous, at any time):
  - state←IDLE, `cnt`←0, `MEM_result`←0.
  - An in-flight store that has not yet committed is aborted, and memory is untouched.
  - After reset with `!req`, `ready`=1.

## Timing
- Reset values: `MEM_result`=0; `ready`=1 when `!req`, 0 when `req`.
- Access occupancy is `WAIT_CYCLES+2` cycles:
  - `ready` is low for `WAIT_CYCLES+1` cycles, then high for 1 cycle in DONE.
  - WAIT_CYCLES=3 gives 4 low cycles followed by 1 high cycle.
- Store commit occurs at the edge that leaves the last WAIT cycle.
- Load data is visible on `MEM_result` in the DONE cycle and held afterwards.
- Back-to-back requests: the next instruction's request is seen in the IDLE cycle right after DONE. `ready` is low in that cycle, so there is no bubble in the FSM.
- Non-memory instructions pass with `ready`=1 and zero added latency.

## Test plan
- **Reset:** assert `rst` mid-cycle with `req`=0 → `ready`=1 and `MEM_result`=0 immediately, without waiting for a clock edge.
- **Store then load:** store `0xDEADBEEF` to 1024, then load from 1024.
  - Each access: `ready` low for exactly 4 cycles, then high 1 cycle.
  - `MEM_result`=`0xDEADBEEF` in the load's DONE cycle.
- **Bounds:**
  - Store `0xA5A5A5A5` to 1276 and load it back → `0xA5A5A5A5`.
  - Store to 1280 → no memory word changes.
  - Loads from 1280 and from 1020 → `MEM_result`=0.
- **Alignment:** with `0xDEADBEEF` at 1024, loads from 1026 and from 1027 → `0xDEADBEEF`.
- **Reset mid-store:**
  - Memory at 1028 holds `0x11111111`.
  - Start a store of `0x12345678` to 1028; assert `rst` during the second WAIT cycle.
  - A later load of 1028 returns `0x11111111`.
- **Hold and priority:**
  - Non-memory cycle after a load of `0xDEADBEEF` → `ready`=1, `MEM_result` stays `0xDEADBEEF`.
  - `MEM_R_EN`=`MEM_W_EN`=1 with `Val_Rm`=`0x0000CAFE` at 1032 → treated as a store, `MEM_result` unchanged; a following load of 1032 returns `0x0000CAFE`.
